// File: rtl/rf_pkg.sv
// Shared definitions for the integer register file, decode and writeback.
// Purpose : address-width helper, dump FSM state encoding, default sizes.
// Ports   : none (package).
package rf_pkg;

    // Default architectural sizes shared by decode, regfile and writeback.
    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int NRD_DEF  = 2;

    // Register index width. Clamped to 1 so a degenerate NREG still
    // produces a legal vector width.
    function automatic int rfAddrW(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

    // Dump sequencer states.
    typedef enum logic {
        DUMP_IDLE = 1'b0,
        DUMP_RUN  = 1'b1
    } dumpState_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Register file bus: read ports, writeback, issue and dump stream.
// Ports   : master = decode/writeback/debug side, slave = register file.
// Widths  : AW = rfAddrW(NREG); read ports packed, port k at [k*W +: W].
interface regfile_mp_if #(
    parameter int XLEN = rf_pkg::XLEN_DEF,
    parameter int NREG = rf_pkg::NREG_DEF,
    parameter int NRD  = rf_pkg::NRD_DEF
);
    import rf_pkg::*;

    localparam int AW = rfAddrW(NREG);

    // Read ports
    logic [NRD*AW-1:0]   iRS_ADDR;
    logic [NRD*XLEN-1:0] oRS_DATA;
    logic [NRD-1:0]      oRS_BUSY;
    // Writeback
    logic                iWE;
    logic [AW-1:0]       iWR_ADDR;
    logic [XLEN-1:0]     iWR_DATA;
    // Issue
    logic                iISSUE;
    logic [AW-1:0]       iISSUE_RD;
    // Dump stream
    logic                iDUMP_REQ;
    logic                oDUMP_VALID;
    logic [AW-1:0]       oDUMP_IDX;
    logic [XLEN-1:0]     oDUMP_DATA;
    logic                oDUMP_DONE;

    modport master (
        output iRS_ADDR, iWE, iWR_ADDR, iWR_DATA, iISSUE, iISSUE_RD, iDUMP_REQ,
        input  oRS_DATA, oRS_BUSY, oDUMP_VALID, oDUMP_IDX, oDUMP_DATA, oDUMP_DONE
    );

    modport slave (
        input  iRS_ADDR, iWE, iWR_ADDR, iWR_DATA, iISSUE, iISSUE_RD, iDUMP_REQ,
        output oRS_DATA, oRS_BUSY, oDUMP_VALID, oDUMP_IDX, oDUMP_DATA, oDUMP_DONE
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard for pipelined issue.
// Ports : iCLK/iRST, writeback clear (iWE/iWR_ADDR), issue set (iISSUE/iISSUE_RD),
//         packed read addresses in, per-port busy flags out (combinational).
module rf_scoreboard #(
    parameter int NREG     = rf_pkg::NREG_DEF,
    parameter int NRD      = rf_pkg::NRD_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int AW       = rf_pkg::rfAddrW(NREG)
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iWE,
    input  logic [AW-1:0]     iWR_ADDR,
    input  logic              iISSUE,
    input  logic [AW-1:0]     iISSUE_RD,
    input  logic [NRD*AW-1:0] iRS_ADDR,
    output logic [NRD-1:0]    oRS_BUSY
);
    import rf_pkg::*;

    logic [NREG-1:0] busyQ;
    logic [NREG-1:0] busyD;

    // Clear first, then set: an issue to the register being written
    // back in the same cycle is a new producer and must stay busy.
    always_comb begin
        busyD = busyQ;
        if (iWE) begin
            busyD[iWR_ADDR] = 1'b0;
        end
        if (iISSUE && !(ZERO_REG != 0 && iISSUE_RD == '0)) begin
            busyD[iISSUE_RD] = 1'b1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            busyQ <= '0;
        end else begin
            busyQ <= busyD;
        end
    end

    // A source being written this cycle gets its value from the bypass,
    // so it is not reported as stalled.
    always_comb begin
        oRS_BUSY = '0;
        for (int k = 0; k < NRD; k++) begin
            if (BYPASS != 0 && iWE && iWR_ADDR == iRS_ADDR[k*AW +: AW]) begin
                oRS_BUSY[k] = 1'b0;
            end else begin
                oRS_BUSY[k] = busyQ[iRS_ADDR[k*AW +: AW]];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with write bypass, busy scoreboard
// and a hardware dump sequencer streaming every register once per request.
// Ports : iCLK, iRST (sync, active high), bus (regfile_mp_if.slave).
module regfile_mp #(
    parameter int XLEN     = rf_pkg::XLEN_DEF,
    parameter int NREG     = rf_pkg::NREG_DEF,
    parameter int NRD      = rf_pkg::NRD_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic         iCLK,
    input  logic         iRST,
    regfile_mp_if.slave  bus
);
    import rf_pkg::*;

    localparam int AW = rfAddrW(NREG);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    // ---------------------------------------------------------------
    // Storage
    // ---------------------------------------------------------------
    logic [XLEN-1:0] regs [NREG];
    logic            wrEn;

    assign wrEn = bus.iWE && !(ZERO_REG != 0 && bus.iWR_ADDR == '0);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wrEn) begin
            regs[bus.iWR_ADDR] <= bus.iWR_DATA;
        end
    end

    // ---------------------------------------------------------------
    // Read ports: hardwired zero beats bypass, bypass beats storage.
    // ---------------------------------------------------------------
    logic [NRD*XLEN-1:0] rsData;

    always_comb begin
        rsData = '0;
        for (int k = 0; k < NRD; k++) begin
            if (ZERO_REG != 0 && bus.iRS_ADDR[k*AW +: AW] == '0) begin
                rsData[k*XLEN +: XLEN] = '0;
            end else if (BYPASS != 0 && bus.iWE && bus.iWR_ADDR == bus.iRS_ADDR[k*AW +: AW]) begin
                rsData[k*XLEN +: XLEN] = bus.iWR_DATA;
            end else begin
                rsData[k*XLEN +: XLEN] = regs[bus.iRS_ADDR[k*AW +: AW]];
            end
        end
    end

    assign bus.oRS_DATA = rsData;

    // ---------------------------------------------------------------
    // Busy scoreboard
    // ---------------------------------------------------------------
    logic [NRD-1:0] rsBusy;

    rf_scoreboard #(
        .NREG     (NREG),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS),
        .AW       (AW)
    ) uScoreboard (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iWE       (bus.iWE),
        .iWR_ADDR  (bus.iWR_ADDR),
        .iISSUE    (bus.iISSUE),
        .iISSUE_RD (bus.iISSUE_RD),
        .iRS_ADDR  (bus.iRS_ADDR),
        .oRS_BUSY  (rsBusy)
    );

    assign bus.oRS_BUSY = rsBusy;

    // ---------------------------------------------------------------
    // Dump sequencer
    // ---------------------------------------------------------------
    dumpState_t      stateQ, stateD;
    logic [AW-1:0]   idxQ, idxD;
    logic            dumpValid;
    logic [AW-1:0]   dumpIdx;
    logic [XLEN-1:0] dumpData;
    logic            dumpDone;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            stateQ <= DUMP_IDLE;
            idxQ   <= '0;
        end else begin
            stateQ <= stateD;
            idxQ   <= idxD;
        end
    end

    // Requests are only looked at in IDLE; one arriving on the final
    // beat is dropped and must be re-asserted.
    always_comb begin
        stateD = stateQ;
        idxD   = idxQ;
        case (stateQ)
            DUMP_IDLE: begin
                if (bus.iDUMP_REQ) begin
                    stateD = DUMP_RUN;
                    idxD   = '0;
                end
            end
            DUMP_RUN: begin
                if (idxQ == LAST_IDX) begin
                    stateD = DUMP_IDLE;
                    idxD   = '0;
                end else begin
                    idxD = idxQ + AW'(1);
                end
            end
            default: begin
                stateD = DUMP_IDLE;
                idxD   = '0;
            end
        endcase
    end

    // Beat data is the stored (pre-edge) value; the bypass is not applied,
    // so a write racing a beat shows up only in later read traffic.
    always_comb begin
        dumpValid = 1'b0;
        dumpIdx   = '0;
        dumpData  = '0;
        dumpDone  = 1'b0;
        if (stateQ == DUMP_RUN) begin
            dumpValid = 1'b1;
            dumpIdx   = idxQ;
            dumpData  = regs[idxQ];
            dumpDone  = (idxQ == LAST_IDX);
        end
    end

    assign bus.oDUMP_VALID = dumpValid;
    assign bus.oDUMP_IDX   = dumpIdx;
    assign bus.oDUMP_DATA  = dumpData;
    assign bus.oDUMP_DONE  = dumpDone;

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: two instances (bypass on / bypass off) share one
// stimulus stream; a reference model predicts every cycle's outputs and a
// monitor process compares them on the falling edge.
module tb_regfile_mp;
    import rf_pkg::*;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic iCLK = 1'b0;
    logic iRST = 1'b1;
    always #5 iCLK = ~iCLK;

    // Stimulus variables driving both interfaces
    logic [NRD*AW-1:0] rsAddr = '0;
    logic              we = 1'b0;
    logic [AW-1:0]     wa = '0;
    logic [XLEN-1:0]   wd = '0;
    logic              issue = 1'b0;
    logic [AW-1:0]     ird = '0;
    logic              dreq = 1'b0;

    regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus0 ();
    regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus1 ();

    assign bus0.iRS_ADDR = rsAddr;  assign bus1.iRS_ADDR = rsAddr;
    assign bus0.iWE      = we;      assign bus1.iWE      = we;
    assign bus0.iWR_ADDR = wa;      assign bus1.iWR_ADDR = wa;
    assign bus0.iWR_DATA = wd;      assign bus1.iWR_DATA = wd;
    assign bus0.iISSUE   = issue;   assign bus1.iISSUE   = issue;
    assign bus0.iISSUE_RD = ird;    assign bus1.iISSUE_RD = ird;
    assign bus0.iDUMP_REQ = dreq;   assign bus1.iDUMP_REQ = dreq;

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .ZERO_REG(1), .BYPASS(1))
        dut0 (.iCLK(iCLK), .iRST(iRST), .bus(bus0));
    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .ZERO_REG(1), .BYPASS(0))
        dut1 (.iCLK(iCLK), .iRST(iRST), .bus(bus1));

    // Expected per-cycle response (index 0 = bypass instance, 1 = no bypass)
    typedef struct packed {
        logic [NRD-1:0][XLEN-1:0] d0;
        logic [NRD-1:0][XLEN-1:0] d1;
        logic [NRD-1:0]           b0;
        logic [NRD-1:0]           b1;
        logic                     dv;
    } cycExp_t;

    typedef struct packed {
        logic [AW-1:0]   idx;
        logic [XLEN-1:0] data;
        logic            done;
    } beat_t;

    cycExp_t cycQ[$];
    beat_t   dumpQ0[$];
    beat_t   dumpQ1[$];

    int compared = 0;
    int mismatched = 0;
    bit monOn = 1'b0;

    // Reference model: architectural state only
    logic [XLEN-1:0] mReg [NREG];
    bit              mBusy [NREG];
    bit              mDumpOn;
    int              mDumpPos;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NREG; i++) begin
            mReg[i]  = '0;
            mBusy[i] = 1'b0;
        end
        mDumpOn  = 1'b0;
        mDumpPos = 0;
    endtask

    // Predict this cycle's outputs, queue them, advance one clock, update model.
    task automatic step();
        cycExp_t e;
        beat_t   b;
        int      a;
        bit      hit;
        e = '0;
        for (int k = 0; k < NRD; k++) begin
            a   = int'(rsAddr[k*AW +: AW]);
            hit = we && (int'(wa) == a);
            e.d0[k] = (a == 0) ? '0 : (hit ? wd : mReg[a]);
            e.d1[k] = (a == 0) ? '0 : mReg[a];
            e.b0[k] = hit ? 1'b0 : mBusy[a];
            e.b1[k] = mBusy[a];
        end
        e.dv = mDumpOn;
        if (mDumpOn) begin
            b.idx  = AW'(mDumpPos);
            b.data = mReg[mDumpPos];
            b.done = (mDumpPos == NREG - 1);
            dumpQ0.push_back(b);
            dumpQ1.push_back(b);
        end
        cycQ.push_back(e);

        @(posedge iCLK);
        if (iRST) begin
            modelReset();
        end else begin
            if (mDumpOn) begin
                if (mDumpPos == NREG - 1) mDumpOn = 1'b0;
                else mDumpPos++;
            end else if (dreq) begin
                mDumpOn  = 1'b1;
                mDumpPos = 0;
            end
            if (we && wa != 0) mReg[wa] = wd;
            if (we) mBusy[wa] = 1'b0;
            if (issue && ird != 0) mBusy[ird] = 1'b1;
        end
        #1;
    endtask

    task automatic idleIn();
        we = 1'b0; wa = '0; wd = '0; issue = 1'b0; ird = '0; dreq = 1'b0; iRST = 1'b0;
    endtask

    function automatic logic [NRD*AW-1:0] addrs(input int a0, input int a1);
        logic [NRD*AW-1:0] r;
        r = {AW'(a1), AW'(a0)};
        return r;
    endfunction

    // Monitor: compares whatever the DUTs present against queued predictions.
    always @(negedge iCLK) begin
        cycExp_t e;
        beat_t   b;
        if (monOn && cycQ.size() > 0) begin
            e = cycQ.pop_front();
            for (int k = 0; k < NRD; k++) begin
                check($sformatf("rd_data_byp p%0d", k), 64'(bus0.oRS_DATA[k*XLEN +: XLEN]), 64'(e.d0[k]));
                check($sformatf("rd_data_nobyp p%0d", k), 64'(bus1.oRS_DATA[k*XLEN +: XLEN]), 64'(e.d1[k]));
                check($sformatf("rd_busy_byp p%0d", k), 64'(bus0.oRS_BUSY[k]), 64'(e.b0[k]));
                check($sformatf("rd_busy_nobyp p%0d", k), 64'(bus1.oRS_BUSY[k]), 64'(e.b1[k]));
            end
            check("dump_valid_byp", 64'(bus0.oDUMP_VALID), 64'(e.dv));
            check("dump_valid_nobyp", 64'(bus1.oDUMP_VALID), 64'(e.dv));
        end
        if (monOn) begin
            if (bus0.oDUMP_VALID === 1'b1) begin
                if (dumpQ0.size() == 0) begin
                    check("dump_unexpected_byp", 64'(1), 64'(0));
                end else begin
                    b = dumpQ0.pop_front();
                    check("dump_idx_byp", 64'(bus0.oDUMP_IDX), 64'(b.idx));
                    check("dump_data_byp", 64'(bus0.oDUMP_DATA), 64'(b.data));
                    check("dump_done_byp", 64'(bus0.oDUMP_DONE), 64'(b.done));
                end
            end else begin
                check("dump_idle_outs_byp", 64'({bus0.oDUMP_DONE, bus0.oDUMP_IDX, bus0.oDUMP_DATA}), 64'(0));
            end
            if (bus1.oDUMP_VALID === 1'b1) begin
                if (dumpQ1.size() == 0) begin
                    check("dump_unexpected_nobyp", 64'(1), 64'(0));
                end else begin
                    b = dumpQ1.pop_front();
                    check("dump_idx_nobyp", 64'(bus1.oDUMP_IDX), 64'(b.idx));
                    check("dump_data_nobyp", 64'(bus1.oDUMP_DATA), 64'(b.data));
                    check("dump_done_nobyp", 64'(bus1.oDUMP_DONE), 64'(b.done));
                end
            end else begin
                check("dump_idle_outs_nobyp", 64'({bus1.oDUMP_DONE, bus1.oDUMP_IDX, bus1.oDUMP_DATA}), 64'(0));
            end
        end
    end

    initial begin
        // Reset: state before the first reset is unknown, so nothing is
        // predicted until it has been applied.
        idleIn();
        iRST = 1'b1;
        @(posedge iCLK);
        @(posedge iCLK);
        #1;
        iRST = 1'b0;
        modelReset();
        monOn = 1'b1;

        // Every address reads zero and idle after reset
        for (int a = 0; a < NREG; a++) begin
            rsAddr = addrs(a, NREG - 1 - a);
            step();
        end

        // Write with same-cycle read of the written register
        we = 1'b1; wa = 5; wd = 32'hDEADBEEF; rsAddr = addrs(5, 5);
        step();
        idleIn(); rsAddr = addrs(5, 0);
        step();

        // Register 0: write and issue are both dropped
        we = 1'b1; wa = 0; wd = 32'h12345678; issue = 1'b1; ird = 0; rsAddr = addrs(0, 0);
        step();
        idleIn();
        step();

        // Scoreboard: issue, collision (set wins), then a lone clearing write
        issue = 1'b1; ird = 7; rsAddr = addrs(7, 5);
        step();
        idleIn(); step();
        issue = 1'b1; ird = 7; we = 1'b1; wa = 7; wd = 32'h0000_0777;
        step();
        idleIn(); step();
        we = 1'b1; wa = 7; wd = 32'h0000_0778;
        step();
        idleIn(); step();

        // Preload reg[i] = i*0x11, then a full dump with the request held
        // through the whole run (including the final beat) before release.
        for (int i = 1; i < NREG; i++) begin
            we = 1'b1; wa = AW'(i); wd = 32'(i * 32'h11); rsAddr = addrs(i, i - 1);
            step();
        end
        idleIn();
        dreq = 1'b1;
        for (int c = 0; c <= NREG; c++) begin
            rsAddr = addrs($urandom_range(NREG - 1), $urandom_range(NREG - 1));
            step();
        end
        dreq = 1'b0;
        step();
        step();

        // Reset mid-dump at beat 10, then a fresh dump of all-zero registers
        dreq = 1'b1; step();
        dreq = 1'b0;
        for (int c = 0; c < 10; c++) step();
        iRST = 1'b1; step();
        iRST = 1'b0; step();
        dreq = 1'b1; step();
        dreq = 1'b0;
        for (int c = 0; c < NREG + 2; c++) step();

        // Randomised traffic
        for (int c = 0; c < 600; c++) begin
            we    = ($urandom_range(1) == 1);
            wa    = AW'($urandom_range(NREG - 1));
            wd    = $urandom();
            issue = ($urandom_range(2) == 0);
            ird   = ($urandom_range(3) == 0) ? wa : AW'($urandom_range(NREG - 1));
            dreq  = ($urandom_range(29) == 0);
            iRST  = ($urandom_range(249) == 0);
            for (int k = 0; k < NRD; k++) begin
                rsAddr[k*AW +: AW] = ($urandom_range(1) == 1) ? wa : AW'($urandom_range(NREG - 1));
            end
            step();
        end

        // Drain any dump still in flight
        idleIn();
        for (int c = 0; c < NREG + 4; c++) step();

        check("dump_leftover_byp", 64'(dumpQ0.size()), 64'(0));
        check("dump_leftover_nobyp", 64'(dumpQ1.size()), 64'(0));
        check("cycle_leftover", 64'(cycQ.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-read-port integer register file for the RV32 core. It adds a write-to-read bypass, a per-register busy scoreboard for pipelined issue, and a hardware dump sequencer that replaces simulation-only register printing. It sits between the decode stage (read addresses, issue) and the writeback stage (write port). It feeds ALU operands and the debug/trace unit.

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of architectural registers (power of 2, >=2)
NRD, 2, number of combinational read ports
ZERO_REG, 1, 1 = register 0 hardwired to zero (writes dropped, never busy)
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
iCLK  in  1  clock, all state updates on rising edge
iRST  in  1  synchronous active-high reset
iRS_ADDR  in  NRD*AW  packed read addresses, port k at [k*AW +: AW], AW=$clog2(NREG)
oRS_DATA  out  NRD*XLEN  packed read data, port k at [k*XLEN +: XLEN]
oRS_BUSY  out  NRD  port k source register has an outstanding producer
iWE  in  1  writeback enable
iWR_ADDR  in  AW  writeback register index
iWR_DATA  in  XLEN  writeback data
iISSUE  in  1  instruction issued that will write iISSUE_RD
iISSUE_RD  in  AW  destination of issued instruction
iDUMP_REQ  in  1  start full register dump
oDUMP_VALID  out  1  dump beat valid
oDUMP_IDX  out  AW  register index of current beat
oDUMP_DATA  out  XLEN  register contents of current beat
oDUMP_DONE  out  1  last dump beat (coincident with final oDUMP_VALID)

Behaviour:
- Reset (iRST high at clock edge): all registers = 0, all busy bits = 0, dump FSM = IDLE, dump index = 0. Reset has priority over write, issue and dump. Outputs after reset: oDUMP_* = 0, oRS_BUSY = 0, oRS_DATA = 0.
- Write: iWE && !(ZERO_REG && iWR_ADDR==0) → reg[iWR_ADDR] <= iWR_DATA at the edge. The new value is visible on a plain read from the next cycle.
- Read: combinational, oRS_DATA[k] = reg[iRS_ADDR[k]].
  - ZERO_REG && addr==0 → 0.
  - Else BYPASS && iWE && iWR_ADDR==addr → iWR_DATA in the same cycle.
  - Multiple ports may read the same address.
- Scoreboard: busy[r] flop per register.
  - iISSUE sets busy[iISSUE_RD] next cycle.
  - iWE clears busy[iWR_ADDR] next cycle.
  - Same register issued and written in the same cycle: set wins (new producer).
  - Register 0 is never set when ZERO_REG=1.
  - oRS_BUSY[k] = busy[addr].
  - With BYPASS=1, the output is masked to 0 when iWE && iWR_ADDR==addr, because the value is forwarded.
- Dump FSM, states IDLE and RUN:
  - IDLE: iDUMP_REQ → RUN with idx=0.
  - RUN: each cycle drives oDUMP_VALID=1, oDUMP_IDX=idx, oDUMP_DATA=reg[idx] (pre-edge value, no bypass), then idx++.
  - At idx==NREG-1, oDUMP_DONE=1 and the FSM returns to IDLE.
  - Total dump = exactly NREG cycles. iDUMP_REQ is ignored in RUN.
  - A request in the same cycle as the return to IDLE is ignored; the requester re-asserts.
  - Writes during a dump are allowed; a register already dumped is not re-sent.
  - Reset mid-dump aborts immediately: oDUMP_VALID=0 next cycle, no DONE pulse.
- Index arithmetic is AW bits unsigned. The dump index never wraps because the FSM exits at NREG-1.
- No X propagation: every out-of-state output is driven to 0.

Decomposition:
- Shared package rf_pkg holds:
  - localparam function for AW = $clog2(NREG)
  - dump state encoding (IDLE=1'b0, RUN=1'b1)
  - default XLEN/NREG constants shared with decode and writeback
- One sub-module rf_scoreboard (busy flops, set/clear priority, BYPASS masking), parameterised by NREG and NRD.
- Storage, read muxing and the dump FSM stay in regfile_mp.

Test Plan:
- Reset: pulse iRST 1 cycle → all read ports return 0 on every address, oRS_BUSY=0, oDUMP_VALID=0.
- Write/bypass: iWE=1, iWR_ADDR=5, iWR_DATA=0xDEADBEEF, iRS_ADDR port0=5 in the same cycle.
  - BYPASS=1 → port0=0xDEADBEEF immediately.
  - BYPASS=0 → old value (0) that cycle, 0xDEADBEEF the next.
- Zero register: write 0x12345678 to reg 0, plus iISSUE with iISSUE_RD=0 → reads of reg 0 return 0, oRS_BUSY for reg 0 stays 0.
- Scoreboard collision:
  - Issue rd=7 → busy next cycle.
  - Then iISSUE rd=7 and iWE addr=7 together → busy remains 1.
  - A later iWE addr=7 alone → busy clears next cycle.
  - With BYPASS=1, oRS_BUSY is 0 during that write cycle.
- Dump: preload reg[i]=i*0x11, pulse iDUMP_REQ → 32 consecutive beats with idx 0..31 and data matching, oDUMP_DONE only on idx 31, then IDLE.
- Reset mid-dump: assert iRST at beat idx=10 → oDUMP_VALID=0 the next cycle, no DONE pulse; a fresh iDUMP_REQ restarts at idx 0 with all-zero data.
